// File: rtl/out_feature_buffer_pkg.sv
// -----------------------------------------------------------------------------
// tdla_ofb_pkg
//   Shared types, default widths and helpers for out_feature_buffer.
//   Contents:
//     ofb_state_e    - collection FSM states
//     DEF_*          - default TM / FEATURE_WIDTH / ADDR_W
//     pair_w()       - width of the pair index within a line (min 1)
//     pair_in_range()- true when a pair index addresses a real feature pair
// -----------------------------------------------------------------------------
package tdla_ofb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } ofb_state_e;

    localparam int DEF_TM            = 4;
    localparam int DEF_FEATURE_WIDTH = 16;
    localparam int DEF_ADDR_W        = 8;

    function automatic int pair_w(input int tm);
        return (tm / 2 <= 1) ? 1 : $clog2(tm / 2);
    endfunction

    // Pair indices past Tm/2 exist when Tm/2 is not a power of two (or Tm=2);
    // those reads return zero.
    function automatic bit pair_in_range(input int unsigned pair, input int unsigned tm);
        return pair < tm / 2;
    endfunction

endpackage

// File: rtl/out_feature_buffer_if.sv
// -----------------------------------------------------------------------------
// out_feature_buffer_if
//   Bus bundle between the decoder/CLP/host side and out_feature_buffer.
//   Write side : frame_start, frame_len, bank_sel_in, feature_valid, feature_i
//   Host side  : rd_en, rd_bank, rd_addr -> rd_data, rd_conflict
//   Status     : busy, frame_done, overflow
//   Modports   : master (drives requests), slave (the buffer).
// -----------------------------------------------------------------------------
interface out_feature_buffer_if
    import tdla_ofb_pkg::*;
#(
    parameter int TM            = DEF_TM,
    parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int PAIR_W        = pair_w(TM)
);
    logic                          frame_start;
    logic [ADDR_W:0]               frame_len;
    logic                          bank_sel_in;
    logic                          feature_valid;
    logic [TM*FEATURE_WIDTH-1:0]   feature_i;
    logic                          rd_en;
    logic                          rd_bank;
    logic [ADDR_W+PAIR_W-1:0]      rd_addr;
    logic [2*FEATURE_WIDTH-1:0]    rd_data;
    logic                          busy;
    logic                          frame_done;
    logic                          overflow;
    logic                          rd_conflict;

    modport master (
        output frame_start, frame_len, bank_sel_in, feature_valid, feature_i,
        output rd_en, rd_bank, rd_addr,
        input  rd_data, busy, frame_done, overflow, rd_conflict
    );

    modport slave (
        input  frame_start, frame_len, bank_sel_in, feature_valid, feature_i,
        input  rd_en, rd_bank, rd_addr,
        output rd_data, busy, frame_done, overflow, rd_conflict
    );
endinterface

// File: rtl/out_feature_buffer_bank.sv
// -----------------------------------------------------------------------------
// ofb_bank
//   Simple dual-port line RAM: one write port, one registered read-first read
//   port. 2^ADDR_W lines of DATA_W bits. Contents are not reset; only the read
//   output register is cleared by rst_n.
//   Ports: clk, rst_n (async low), we/wr_addr/wr_data, re/rd_addr -> rd_data
// -----------------------------------------------------------------------------
module ofb_bank #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Separate process from the write: a same-address read in the write cycle
    // returns the old line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rd_data <= '0;
        else if (re) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/out_feature_buffer.sv
// -----------------------------------------------------------------------------
// out_feature_buffer
//   Ping-pong output buffer behind the CLP. A frame_start latches the target
//   bank and line count; each feature_valid word in COLLECT is written to the
//   next line. The host reads two features per access with 1-cycle latency.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - out_feature_buffer_if.slave (write side, host read side, status)
//   Build option:
//     OFB_RELU_EN - when defined, negative features are clamped to 0 on write.
// -----------------------------------------------------------------------------
module out_feature_buffer
    import tdla_ofb_pkg::*;
#(
    parameter int TM            = DEF_TM,
    parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    out_feature_buffer_if.slave  bus
);
    localparam int PAIR_W = pair_w(TM);
    localparam int NPAIR  = TM / 2;
    localparam int LINE_W = TM * FEATURE_WIDTH;
    localparam logic [ADDR_W:0] LEN_ONE = 1;

    ofb_state_e                         state, state_n;
    logic [ADDR_W-1:0]                  wr_ptr;
    logic [ADDR_W:0]                    len_q;
    logic                               wr_bank;
    logic                               frame_done_q, done_n;
    logic                               overflow_q;
    logic                               conflict_q;
    logic                               rd_bank_q;
    logic [PAIR_W-1:0]                  pair_q;
    logic                               wr_en, last_line, len_zero;
    logic [TM-1:0][FEATURE_WIDTH-1:0]   feat_in, feat_wr;
    logic [1:0][LINE_W-1:0]             bank_rd;
    logic [LINE_W-1:0]                  rd_line;
    logic [2*FEATURE_WIDTH-1:0]         rd_mux;

    assign feat_in   = bus.feature_i;
    assign len_zero  = (bus.frame_len == '0);
    // frame_start outranks a same-cycle word, which is dropped.
    assign wr_en     = (state == COLLECT) && bus.feature_valid && !bus.frame_start;
    assign last_line = ({1'b0, wr_ptr} == (len_q - LEN_ONE));

    // Per-feature write-path conditioning.
    for (genvar k = 0; k < TM; k++) begin : g_feat
`ifdef OFB_RELU_EN
        assign feat_wr[k] = feat_in[k][FEATURE_WIDTH-1] ? '0 : feat_in[k];
`else
        assign feat_wr[k] = feat_in[k];
`endif
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        if (bus.frame_start) begin
            // Also the abort path out of COLLECT: restart with the new frame.
            if (len_zero) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = COLLECT;
            end
        end else if (wr_en && last_line) begin
            state_n = DONE;
            done_n  = 1'b1;
        end
    end

    // ---------------- write control, flags, read tracking ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            len_q        <= '0;
            wr_bank      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            conflict_q   <= 1'b0;
            rd_bank_q    <= 1'b0;
            pair_q       <= '0;
        end else begin
            frame_done_q <= done_n;
            if (bus.frame_start) begin
                wr_bank <= bus.bank_sel_in;
                len_q   <= bus.frame_len;
                wr_ptr  <= '0;
            end else if (wr_en) begin
                wr_ptr  <= wr_ptr + ADDR_W'(1);
            end
            // Sticky: dropped word, or a frame aborted by a new frame_start.
            if ((bus.feature_valid && (state != COLLECT || bus.frame_start)) ||
                (bus.frame_start && state == COLLECT))
                overflow_q <= 1'b1;
            conflict_q <= bus.rd_en && (state == COLLECT) && (bus.rd_bank == wr_bank);
            if (bus.rd_en) begin
                rd_bank_q <= bus.rd_bank;
                pair_q    <= bus.rd_addr[PAIR_W-1:0];
            end
        end
    end

    // ---------------- banks ----------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        ofb_bank #(
            .DATA_W (LINE_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst),
            .we      (wr_en && (wr_bank == 1'(b))),
            .wr_addr (wr_ptr),
            .wr_data (feat_wr),
            .re      (bus.rd_en && (bus.rd_bank == 1'(b))),
            .rd_addr (bus.rd_addr[ADDR_W+PAIR_W-1:PAIR_W]),
            .rd_data (bank_rd[b])
        );
    end

    // Pair select acts on registered line/bank/pair, so rd_data holds while
    // rd_en is low and is zero out of reset.
    assign rd_line = bank_rd[rd_bank_q];

    always_comb begin
        rd_mux = '0;
        if (pair_in_range(32'(pair_q), TM)) begin
            for (int p = 0; p < NPAIR; p++) begin
                if (pair_q == PAIR_W'(p))
                    rd_mux = rd_line[p*2*FEATURE_WIDTH +: 2*FEATURE_WIDTH];
            end
        end
    end

    assign bus.rd_data     = rd_mux;
    assign bus.busy        = (state == COLLECT);
    assign bus.frame_done  = frame_done_q;
    assign bus.overflow    = overflow_q;
    assign bus.rd_conflict = conflict_q;
endmodule

// File: tb/tb_out_feature_buffer.sv
// Directed bench for out_feature_buffer (TM=4, FEATURE_WIDTH=16, ADDR_W=8).
module tb_out_feature_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    out_feature_buffer_if bus_if ();

    out_feature_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int len, input logic bank);
        bus_if.frame_start = 1'b1;
        bus_if.frame_len   = 9'(len);
        bus_if.bank_sel_in = bank;
        tick();
        bus_if.frame_start = 1'b0;
    endtask

    task automatic rd(input logic bank, input int line, input logic pair);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_bank = bank;
        bus_if.rd_addr = {8'(line), pair};
        tick();
        bus_if.rd_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.frame_start   = 1'b0;
        bus_if.frame_len     = '0;
        bus_if.bank_sel_in   = 1'b0;
        bus_if.feature_valid = 1'b0;
        bus_if.feature_i     = '0;
        bus_if.rd_en         = 1'b0;
        bus_if.rd_bank       = 1'b0;
        bus_if.rd_addr       = '0;

        // reset state
        repeat (3) tick();
        check("rst_busy",     64'(bus_if.busy),        64'd0);
        check("rst_done",     64'(bus_if.frame_done),  64'd0);
        check("rst_ovf",      64'(bus_if.overflow),    64'd0);
        check("rst_conflict", 64'(bus_if.rd_conflict), 64'd0);
        check("rst_rdata",    64'(bus_if.rd_data),     64'd0);
        rst = 1'b1;
        tick();

        // normal frame, 3 lines into bank 0
        start(3, 1'b0);
        check("n_busy", 64'(bus_if.busy), 64'd1);
        bus_if.feature_valid = 1'b1;
        bus_if.feature_i = 64'h0004_0003_0002_0001; tick();
        bus_if.feature_i = 64'h0008_0007_0006_0005; tick();
        check("n_done_early", 64'(bus_if.frame_done), 64'd0);
        bus_if.feature_i = 64'h000C_000B_000A_0009; tick();
        bus_if.feature_valid = 1'b0;
        check("n_done",      64'(bus_if.frame_done), 64'd1);
        check("n_busy_fall", 64'(bus_if.busy),       64'd0);
        tick();
        check("n_done_pulse", 64'(bus_if.frame_done), 64'd0);
        rd(1'b0, 1, 1'b1);
        check("n_rd_1_1", 64'(bus_if.rd_data), 64'h0008_0007);
        rd(1'b0, 2, 1'b0);
        check("n_rd_2_0", 64'(bus_if.rd_data), 64'h000A_0009);
        tick();
        check("n_rd_hold", 64'(bus_if.rd_data), 64'h000A_0009);
        rd(1'b0, 0, 1'b0);
        check("n_rd_0_0", 64'(bus_if.rd_data), 64'h0002_0001);

        // ping-pong: frame into bank 1 while host reads bank 0
        start(2, 1'b1);
        bus_if.feature_valid = 1'b1;
        bus_if.feature_i = 64'h0014_0013_0012_0011;
        bus_if.rd_en = 1'b1; bus_if.rd_bank = 1'b0; bus_if.rd_addr = {8'd1, 1'b0};
        tick();
        check("pp_rd_b0",   64'(bus_if.rd_data),     64'h0006_0005);
        check("pp_noconf",  64'(bus_if.rd_conflict), 64'd0);
        check("pp_busy",    64'(bus_if.busy),        64'd1);
        bus_if.feature_i = 64'h0018_0017_0016_0015;
        bus_if.rd_bank = 1'b1; bus_if.rd_addr = {8'd0, 1'b0};
        tick();
        bus_if.feature_valid = 1'b0;
        check("pp_conf",    64'(bus_if.rd_conflict), 64'd1);
        check("pp_rd_b1",   64'(bus_if.rd_data),     64'h0012_0011);
        check("pp_done",    64'(bus_if.frame_done),  64'd1);
        bus_if.rd_bank = 1'b0; bus_if.rd_addr = {8'd2, 1'b1};
        tick();
        bus_if.rd_en = 1'b0;
        check("pp_b0_keep", 64'(bus_if.rd_data),     64'h000C_000B);
        check("pp_conf_lo", 64'(bus_if.rd_conflict), 64'd0);
        check("pp_no_ovf",  64'(bus_if.overflow),    64'd0);
        rd(1'b1, 1, 1'b1);
        check("pp_rd_b1_l1", 64'(bus_if.rd_data), 64'h0018_0017);

        // overflow: word outside COLLECT, then start+valid together
        bus_if.feature_valid = 1'b1;
        bus_if.feature_i = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        bus_if.feature_valid = 1'b0;
        check("ov_idle", 64'(bus_if.overflow), 64'd1);
        bus_if.feature_valid = 1'b1;
        start(2, 1'b0);
        bus_if.feature_i = 64'h0024_0023_0022_0021; tick();
        bus_if.feature_i = 64'h0028_0027_0026_0025; tick();
        bus_if.feature_valid = 1'b0;
        check("ov_done",   64'(bus_if.frame_done), 64'd1);
        check("ov_sticky", 64'(bus_if.overflow),   64'd1);
        rd(1'b0, 0, 1'b0);
        check("ov_line0", 64'(bus_if.rd_data), 64'h0022_0021);
        rd(1'b0, 1, 1'b1);
        check("ov_line1", 64'(bus_if.rd_data), 64'h0028_0027);

        // abort: len 5, two words, restart with len 1
        start(5, 1'b1);
        bus_if.feature_valid = 1'b1;
        bus_if.feature_i = 64'h0034_0033_0032_0031; tick();
        bus_if.feature_i = 64'h0038_0037_0036_0035; tick();
        bus_if.feature_valid = 1'b0;
        start(1, 1'b1);
        check("ab_no_done", 64'(bus_if.frame_done), 64'd0);
        check("ab_busy",    64'(bus_if.busy),       64'd1);
        bus_if.feature_valid = 1'b1;
        bus_if.feature_i = 64'h0044_0043_0042_0041; tick();
        bus_if.feature_valid = 1'b0;
        check("ab_done", 64'(bus_if.frame_done), 64'd1);
        check("ab_idle", 64'(bus_if.busy),       64'd0);
        rd(1'b1, 0, 1'b0);
        check("ab_line0", 64'(bus_if.rd_data), 64'h0042_0041);

        // frame_len = 0
        start(0, 1'b0);
        check("z_done", 64'(bus_if.frame_done), 64'd1);
        check("z_busy", 64'(bus_if.busy),       64'd0);
        tick();
        check("z_pulse", 64'(bus_if.frame_done), 64'd0);

        // frame_len = 256 fills bank 0
        start(256, 1'b0);
        bus_if.feature_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus_if.feature_i = {16'(i + 3), 16'(i + 2), 16'(i + 1), 16'(i)};
            tick();
            if (i == 254) check("f_not_done", 64'(bus_if.frame_done), 64'd0);
        end
        bus_if.feature_valid = 1'b0;
        check("f_done", 64'(bus_if.frame_done), 64'd1);
        check("f_busy", 64'(bus_if.busy),       64'd0);
        rd(1'b0, 255, 1'b1);
        check("f_l255", 64'(bus_if.rd_data), 64'h0102_0101);
        rd(1'b0, 0, 1'b0);
        check("f_l0",   64'(bus_if.rd_data), 64'h0001_0000);
        rd(1'b0, 128, 1'b1);
        check("f_l128", 64'(bus_if.rd_data), 64'h0083_0082);

        // write-path conditioning
        start(1, 1'b0);
        bus_if.feature_valid = 1'b1;
        bus_if.feature_i = 64'hFFFF_0005_8000_7FFF; tick();
        bus_if.feature_valid = 1'b0;
        check("r_done", 64'(bus_if.frame_done), 64'd1);
        rd(1'b0, 0, 1'b0);
`ifdef OFB_RELU_EN
        check("r_pair0", 64'(bus_if.rd_data), 64'h0000_7FFF);
`else
        check("r_pair0", 64'(bus_if.rd_data), 64'h8000_7FFF);
`endif
        rd(1'b0, 0, 1'b1);
`ifdef OFB_RELU_EN
        check("r_pair1", 64'(bus_if.rd_data), 64'h0000_0005);
`else
        check("r_pair1", 64'(bus_if.rd_data), 64'hFFFF_0005);
`endif

        // asynchronous reset mid-frame
        start(3, 1'b1);
        bus_if.feature_valid = 1'b1;
        bus_if.feature_i = 64'h0054_0053_0052_0051; tick();
        bus_if.feature_valid = 1'b0;
        check("ar_busy_pre", 64'(bus_if.busy), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("ar_busy",  64'(bus_if.busy),     64'd0);
        check("ar_ovf",   64'(bus_if.overflow), 64'd0);
        check("ar_rdata", 64'(bus_if.rd_data),  64'd0);
        check("ar_done",  64'(bus_if.frame_done), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        bus_if.feature_valid = 1'b1;
        tick();
        bus_if.feature_valid = 1'b0;
        check("ar_idle",     64'(bus_if.busy),     64'd0);
        check("ar_ovf_idle", 64'(bus_if.overflow), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
